// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_mem_loader_if : byte-stream handshake plus instruction-memory write bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface instr_mem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  // master: stream source and memory-bus observer; slave: the loader itself
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// instr_mem_loader : framed byte stream -> big-endian words written from address 0
// Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte. Rev 1.0
// ----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_start,
  instr_mem_loader_if.slave bus,
  output logic              o_cpu_stall,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_LEN_HI = 3'd1;
  localparam logic [2:0] c_LEN_LO = 3'd2;
  localparam logic [2:0] c_DATA   = 3'd3;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] c_CHK    = 3'd4;
  localparam logic [2:0] c_TAIL   = c_CHK;
`else
  localparam logic [2:0] c_TAIL   = 3'd5;
`endif
  localparam logic [2:0] c_DONE   = 3'd5;

  // 17 bits so DEPTH itself is representable for ADDR_WIDTH up to 16
  localparam logic [16:0] c_DEPTH = 17'd1 << ADDR_WIDTH;

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic                  w_in_ready;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_accept;
  logic [15:0]           r_len;
  logic [15:0]           w_len_full;
  logic                  w_len_over;
  logic                  w_len_zero;
  logic [15:0]           r_word_idx;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_shift;
  logic                  w_last_byte;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_xor;
`endif

  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_len_full  = {r_len[15:8], bus.in_data};
  assign w_len_over  = {1'b0, w_len_full} > c_DEPTH;
  assign w_len_zero  = (w_len_full == 16'd0);
  assign w_last_byte = (r_byte_cnt == 2'd3) && (r_word_idx == r_len - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (i_start) w_next = c_LEN_HI;
      c_LEN_HI: if (w_accept) w_next = c_LEN_LO;
      c_LEN_LO: begin
        if (w_accept) begin
          if (w_len_over)      w_next = c_DONE;
          else if (w_len_zero) w_next = c_TAIL;
          else                 w_next = c_DATA;
        end
      end
      c_DATA:   if (w_accept && w_last_byte) w_next = c_TAIL;
`ifdef LOADER_CHECKSUM_EN
      c_CHK:    if (w_accept) w_next = c_DONE;
`endif
      c_DONE:   if (i_start) w_next = c_LEN_HI;
      default:  w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      c_LEN_HI, c_LEN_LO, c_DATA: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      c_CHK: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
      end
`endif
      c_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len       <= 16'd0;
      r_word_idx  <= 16'd0;
      r_byte_cnt  <= 2'd0;
      r_shift     <= 24'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor       <= 8'd0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        c_IDLE, c_DONE: begin
          if (i_start) begin
            r_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor   <= 8'd0;
`endif
          end
        end
        c_LEN_HI: if (w_accept) r_len[15:8] <= bus.in_data;
        c_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= bus.in_data;
            r_word_idx <= 16'd0;
            r_byte_cnt <= 2'd0;
            if (w_len_over) r_error <= 1'b1;
          end
        end
        c_DATA: begin
          if (w_accept) begin
            r_shift    <= {r_shift[15:0], bus.in_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_xor      <= r_xor ^ bus.in_data;
`endif
            // fourth byte completes the word; write it out next cycle
            if (r_byte_cnt == 2'd3) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
              r_mem_wdata <= {r_shift, bus.in_data};
              r_word_idx  <= r_word_idx + 16'd1;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        c_CHK: if (w_accept && (bus.in_data != r_xor)) r_error <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign o_cpu_stall   = w_busy;
  assign o_done        = w_done;
  assign o_error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_instr_mem_loader : scoreboard bench driving a depth-256 and a depth-4 loader
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_instr_mem_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit c_CHK_EN = 1'b1;
`else
  localparam bit c_CHK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] d;
  logic       v;
  logic       stall8, done8, err8;
  logic       stall2, done2, err2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t q8[$];
  wr_t q2[$];
  logic [7:0] f1[$];
  logic [7:0] fb[$];

  always #5 clk = ~clk;

  instr_mem_loader_if #(.ADDR_WIDTH(8)) bus8 ();
  instr_mem_loader_if #(.ADDR_WIDTH(2)) bus2 ();

  assign bus8.in_data  = d;
  assign bus8.in_valid = v;
  assign bus2.in_data  = d;
  assign bus2.in_valid = v;

  instr_mem_loader #(.ADDR_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .i_start(start), .bus(bus8),
    .o_cpu_stall(stall8), .o_done(done8), .o_error(err8)
  );

  instr_mem_loader #(.ADDR_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .i_start(start), .bus(bus2),
    .o_cpu_stall(stall2), .o_done(done2), .o_error(err2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus8.mem_we === 1'b1) begin
      if (q8.size() == 0) chk("we8_unexpected", 1, 0);
      else begin
        wr_t e;
        e = q8.pop_front();
        chk("we8_addr", 64'(bus8.mem_addr), 64'(e.addr));
        chk("we8_data", 64'(bus8.mem_wdata), 64'(e.data));
        chk("we8_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (bus2.mem_we === 1'b1) begin
      if (q2.size() == 0) chk("we2_unexpected", 1, 0);
      else begin
        wr_t e;
        e = q2.pop_front();
        chk("we2_addr", 64'(bus2.mem_addr), 64'(e.addr));
        chk("we2_data", 64'(bus2.mem_wdata), 64'(e.data));
        chk("we2_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic exp_wr(input logic [7:0] a, input logic [31:0] w, input int c,
                        input bit ok8, input bit ok2);
    wr_t e;
    e.addr = a;
    e.data = w;
    e.cyc  = c;
    if (ok8) q8.push_back(e);
    if (ok2) q2.push_back(e);
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    d = b;
    v = 1'b1;
  endtask

  task automatic gap();
    @(negedge clk);
    d = 8'($urandom);
    v = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    v     = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("stall_after_start", {stall8, stall2}, 2'b11);
    chk("ready_after_start", {bus8.in_ready, bus2.in_ready}, 2'b11);
    chk("done_err_cleared", {done8, err8, done2, err2}, 4'b0000);
  endtask

  task automatic check_idle(input string tag);
    chk(tag, {bus8.in_ready, bus8.mem_we, bus8.mem_addr, bus8.mem_wdata, stall8, done8, err8}, 0);
    chk(tag, {bus2.in_ready, bus2.mem_we, bus2.mem_addr, bus2.mem_wdata, stall2, done2, err2}, 0);
  endtask

  task automatic send_frame(input logic [15:0] n, input logic [7:0] b[$],
                            input bit gaps, input bit bad_chk);
    logic [7:0]  x;
    logic [31:0] w;
    bit          ok8, ok2;
    x   = 8'h00;
    w   = 32'h0;
    ok8 = (n <= 16'd256);
    ok2 = (n <= 16'd4);
    put(n[15:8]);
    if (gaps) gap();
    put(n[7:0]);
    foreach (b[i]) begin
      if (gaps) gap();
      put(b[i]);
      x = x ^ b[i];
      w = {w[23:0], b[i]};
      if (i % 4 == 3) exp_wr(8'(i / 4), w, cyc + 1, ok8, ok2);
    end
`ifdef LOADER_CHECKSUM_EN
    if (gaps) gap();
    put(x ^ {7'd0, bad_chk});
`endif
    @(negedge clk);
    v = 1'b0;
    // the last write and done land in the same cycle
    chk("done8", done8, 1'b1);
    chk("err8", err8, !ok8 || (c_CHK_EN && bad_chk));
    chk("done2", done2, 1'b1);
    chk("err2", err2, !ok2 || (c_CHK_EN && bad_chk));
    chk("released", {stall8, stall2, bus8.in_ready, bus2.in_ready}, 4'b0000);
    chk("sb8_drained", 64'(q8.size()), 0);
    chk("sb2_drained", 64'(q2.size()), 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    d     = 8'h00;
    v     = 1'b0;
    f1 = '{8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h23, 8'h00, 8'h00};
    repeat (3) @(negedge clk);
    check_idle("reset_outputs");
    rst = 1'b0;

    do_start();
    send_frame(16'd2, f1, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_held", done8, 1'b1);

    do_start();
    send_frame(16'd2, f1, 1'b1, 1'b0);

    // 5 words overflows the depth-4 loader only
    fb = {};
    for (int i = 0; i < 20; i++) fb.push_back(8'(8'h30 + i));
    do_start();
    send_frame(16'd5, fb, 1'b0, 1'b0);

    fb = {};
    for (int i = 0; i < 16; i++) fb.push_back(8'($urandom));
    do_start();
    send_frame(16'd4, fb, 1'b0, 1'b0);

    fb = {};
    do_start();
    send_frame(16'd0, fb, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    fb = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_start();
    send_frame(16'd1, fb, 1'b0, 1'b0);
    do_start();
    send_frame(16'd1, fb, 1'b1, 1'b1);
`endif

    do_start();
    put(8'h00);
    put(8'h02);
    for (int i = 0; i < 6; i++) begin
      put(f1[i]);
      if (i == 3) exp_wr(8'd0, 32'h20010005, cyc + 1, 1'b1, 1'b1);
    end
    @(negedge clk);
    v   = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midload_reset");
    repeat (3) @(negedge clk);
    chk("no_write_after_reset", {bus8.mem_we, bus2.mem_we}, 2'b00);

    do_start();
    send_frame(16'd2, f1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("final_sb8", 64'(q8.size()), 0);
    chk("final_sb2", 64'(q2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
